// File: rtl/umio_tx_arb_if.sv
// Bus bundle for umio_tx_arb: both FIFO read ports and the MAC TX byte stream.
// master = the arbiter, slave = the FIFOs/MAC around it.
interface umio_tx_arb_if;
    logic [8:0] src0_data;
    logic       src0_empty;
    logic       src0_rd_en;
    logic       src0_frm_wr;
    logic [8:0] src1_data;
    logic       src1_empty;
    logic       src1_rd_en;
    logic       src1_frm_wr;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       grant;
    logic       busy;

    modport master (
        input  src0_data, src0_empty, src0_frm_wr,
        input  src1_data, src1_empty, src1_frm_wr,
        input  tx_ready,
        output src0_rd_en, src1_rd_en,
        output tx_data, tx_last, tx_valid, grant, busy
    );

    modport slave (
        output src0_data, src0_empty, src0_frm_wr,
        output src1_data, src1_empty, src1_frm_wr,
        output tx_ready,
        input  src0_rd_en, src1_rd_en,
        input  tx_data, tx_last, tx_valid, grant, busy
    );
endinterface

// File: rtl/umio_tx_arb.sv
// Two-source round-robin frame arbiter feeding the MAC TX byte stream.
// A frame is only started once the writer has committed it completely
// (per-source complete-frame counters), so the MAC never underruns mid-frame
// unless the FIFO itself runs dry. A programmable gap follows every frame.
// Optional: UMIO_TX_ARB_STAT_EN adds per-source frame statistics and a sticky
// frame-counter saturation flag.
//
// state | meaning
// IDLE  | pick a source with a complete frame (priority source first)
// XFER  | stream the granted FIFO to the MAC until its last byte is popped
// GAP   | inter-frame gap, IFG_LEN idle cycles
module umio_tx_arb #(
    parameter int CNT_W   = 6,
    parameter int IFG_LEN = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    umio_tx_arb_if.master bus
`ifdef UMIO_TX_ARB_STAT_EN
    ,
    output logic [15:0]  stat_frm0,
    output logic [15:0]  stat_frm1,
    output logic         stat_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       IFG     = 8'(IFG_LEN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] frm_cnt0, frm_cnt1;
    logic             grant, grant_nxt;
    logic             rr_pri, rr_pri_nxt;
    logic [7:0]       gap_cnt, gap_nxt;

    logic [8:0] head;
    logic       head_empty;
    logic       in_xfer;
    logic       tx_valid_i;
    logic       pop;
    logic       pop_last0, pop_last1;

    assign head       = grant ? bus.src1_data  : bus.src0_data;
    assign head_empty = grant ? bus.src1_empty : bus.src0_empty;
    assign in_xfer    = (state == XFER);
    assign tx_valid_i = in_xfer & ~head_empty;
    assign pop        = tx_valid_i & bus.tx_ready;
    assign pop_last0  = pop & head[8] & ~grant;
    assign pop_last1  = pop & head[8] & grant;

    assign bus.tx_valid   = tx_valid_i;
    assign bus.tx_data    = in_xfer ? head[7:0] : 8'h00;
    assign bus.tx_last    = in_xfer & head[8];
    assign bus.src0_rd_en = pop & ~grant;
    assign bus.src1_rd_en = pop & grant;
    assign bus.grant      = grant;
    assign bus.busy       = (state != IDLE);

    // Simultaneous commit and last-byte pop cancel; increment saturates.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = cnt;
        if (inc && !dec && cnt != CNT_MAX)
            r = cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            r = cnt - 1'b1;
        return r;
    endfunction

    // Complete-frame counters, one per source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt0 <= '0;
            frm_cnt1 <= '0;
        end else begin
            frm_cnt0 <= cnt_next(frm_cnt0, bus.src0_frm_wr, pop_last0);
            frm_cnt1 <= cnt_next(frm_cnt1, bus.src1_frm_wr, pop_last1);
        end
    end

    // FSM state, grant, round-robin pointer and gap timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 1'b0;
            rr_pri  <= 1'b0;
            gap_cnt <= 8'h00;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_pri  <= rr_pri_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next-state: arbitration in IDLE, frame end detection in XFER, gap countdown.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_pri_nxt = rr_pri;
        gap_nxt    = gap_cnt;
        unique case (state)
            IDLE: begin
                if ((rr_pri ? frm_cnt1 : frm_cnt0) != '0) begin
                    grant_nxt = rr_pri;
                    state_nxt = XFER;
                end else if ((rr_pri ? frm_cnt0 : frm_cnt1) != '0) begin
                    grant_nxt = ~rr_pri;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (pop && head[8]) begin
                    rr_pri_nxt = ~grant;
                    gap_nxt    = IFG;
                    state_nxt  = (IFG != 8'h00) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - 8'd1;
                if (gap_cnt <= 8'd1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UMIO_TX_ARB_STAT_EN
    // Per-source transmitted-frame counts and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frm0 <= 16'h0000;
            stat_frm1 <= 16'h0000;
            stat_ovf  <= 1'b0;
        end else begin
            if (pop_last0)
                stat_frm0 <= stat_frm0 + 16'd1;
            if (pop_last1)
                stat_frm1 <= stat_frm1 + 16'd1;
            if ((bus.src0_frm_wr && !pop_last0 && frm_cnt0 == CNT_MAX) ||
                (bus.src1_frm_wr && !pop_last1 && frm_cnt1 == CNT_MAX))
                stat_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_umio_tx_arb.sv
// Bench for umio_tx_arb: instance A uses IFG_LEN=12, instance B uses IFG_LEN=0.
// Show-ahead FIFO models feed both; a monitor per instance pops the expected
// byte queue on every accepted byte and checks holding during stalls.
module tb_umio_tx_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    umio_tx_arb_if bus [2] ();

    logic       frm_wr_v [4];
    logic       tx_ready_v [2];
    logic [8:0] fq [4][$];
    logic [9:0] exp_q [2][$];

    logic       vld [2];
    logic       busy_w [2];
    logic       grant_w [2];
    logic       last_w [2];
    logic [7:0] data_w [2];
    logic       rd0_w [2];
    logic       rd1_w [2];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef UMIO_TX_ARB_STAT_EN
    logic [15:0] sa0, sa1, sb0, sb1;
    logic        soa, sob;
`endif

    umio_tx_arb #(.CNT_W(6), .IFG_LEN(12)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[0])
`ifdef UMIO_TX_ARB_STAT_EN
        , .stat_frm0(sa0), .stat_frm1(sa1), .stat_ovf(soa)
`endif
    );

    umio_tx_arb #(.CNT_W(6), .IFG_LEN(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[1])
`ifdef UMIO_TX_ARB_STAT_EN
        , .stat_frm0(sb0), .stat_frm1(sb1), .stat_ovf(sob)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar d = 0; d < 2; d++) begin : g_env
        logic [8:0] held;
        bit         holding = 1'b0;
        logic [9:0] e;

        assign bus[d].src0_frm_wr = frm_wr_v[2*d];
        assign bus[d].src1_frm_wr = frm_wr_v[2*d+1];
        assign bus[d].tx_ready    = tx_ready_v[d];
        assign vld[d]     = bus[d].tx_valid;
        assign busy_w[d]  = bus[d].busy;
        assign grant_w[d] = bus[d].grant;
        assign last_w[d]  = bus[d].tx_last;
        assign data_w[d]  = bus[d].tx_data;
        assign rd0_w[d]   = bus[d].src0_rd_en;
        assign rd1_w[d]   = bus[d].src1_rd_en;

        // Show-ahead FIFO models; pushes become visible at the next rising edge.
        always @(posedge clk) begin
            if (bus[d].src0_rd_en && fq[2*d].size() > 0)
                void'(fq[2*d].pop_front());
            if (bus[d].src1_rd_en && fq[2*d+1].size() > 0)
                void'(fq[2*d+1].pop_front());
            bus[d].src0_data  <= (fq[2*d].size() > 0)   ? fq[2*d][0]   : 9'h000;
            bus[d].src0_empty <= (fq[2*d].size() == 0);
            bus[d].src1_data  <= (fq[2*d+1].size() > 0) ? fq[2*d+1][0] : 9'h000;
            bus[d].src1_empty <= (fq[2*d+1].size() == 0);
        end

        // Output monitor / scoreboard.
        always @(negedge clk) begin
            #1;
            if (!rst_n) begin
                holding = 1'b0;
            end else if (vld[d]) begin
                if (holding)
                    chk("hold_stable", {23'd0, last_w[d], data_w[d]}, {23'd0, held});
                if (tx_ready_v[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none", data_w[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk("byte", {22'd0, grant_w[d], last_w[d], data_w[d]}, {22'd0, e});
                    end
                    chk("rd_en_pop", {30'd0, rd1_w[d], rd0_w[d]},
                        grant_w[d] ? 32'd2 : 32'd1);
                    holding = 1'b0;
                end else begin
                    chk("rd_en_stall", {30'd0, rd1_w[d], rd0_w[d]}, 32'd0);
                    held    = {last_w[d], data_w[d]};
                    holding = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic push_byte(input int d, input int s, input logic [7:0] b,
                             input logic last, input bit expect_out);
        fq[2*d+s].push_back({last, b});
        if (expect_out)
            exp_q[d].push_back({s[0], last, b});
    endtask

    task automatic push_frame(input int d, input int s, input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++)
            push_byte(d, s, base + 8'(i), (i == len - 1), 1'b1);
    endtask

    task automatic wait_valid(input int d, input string nm);
        int n;
        n = 0;
        while (!vld[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!vld[d]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout waiting for tx_valid", nm);
        end
    endtask

    task automatic wait_done(input int d, input string nm);
        int n;
        n = 0;
        while ((exp_q[d].size() != 0 || busy_w[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, exp_q[d].size(), 0);
        chk({nm, "_idle"}, {31'd0, busy_w[0]}, 0);
    endtask

    logic [10:0] vpat;
    int          gap_n;

    initial begin
        for (int i = 0; i < 4; i++) frm_wr_v[i] = 1'b0;
        tx_ready_v[0] = 1'b1;
        tx_ready_v[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", {31'd0, vld[d]}, 0);
            chk("rst_busy",  {31'd0, busy_w[d]}, 0);
            chk("rst_grant", {31'd0, grant_w[d]}, 0);
            chk("rst_rd_en", {30'd0, rd1_w[d], rd0_w[d]}, 0);
            chk("rst_data",  {23'd0, last_w[d], data_w[d]}, 0);
        end
        chk("rst_cnt_a", {20'd0, u_dut_a.frm_cnt1, u_dut_a.frm_cnt0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single 3-byte frame on instance A, latency and 12-cycle gap
        push_frame(0, 0, 8'hA1, 3);
        frm_wr_v[0] = 1'b1;
        @(negedge clk);
        frm_wr_v[0] = 1'b0;
        chk("t1_idle_cycle", {31'd0, vld[0]}, 0);
        chk("t1_idle_busy", {31'd0, busy_w[0]}, 0);
        chk("t1_cnt_one", {26'd0, u_dut_a.frm_cnt0}, 1);
        @(negedge clk);
        chk("t1_lat2", {31'd0, vld[0]}, 1);
        @(negedge clk);
        chk("t1_byte2_valid", {31'd0, vld[0]}, 1);
        @(negedge clk);
        chk("t1_byte3_last", {23'd0, vld[0] & last_w[0], data_w[0]}, 32'h1A3);
        @(negedge clk);
        chk("t1_cnt_zero", {26'd0, u_dut_a.frm_cnt0}, 0);
        for (int i = 0; i < 12; i++) begin
            chk("t1_gap", {30'd0, vld[0], busy_w[0]}, 1);
            @(negedge clk);
        end
        chk("t1_busy_after_gap", {31'd0, busy_w[0]}, 0);

        // T2: instance B, two 2-byte frames per source, IFG_LEN=0
        push_frame(1, 0, 8'hB0, 2);
        push_frame(1, 1, 8'hC0, 2);
        push_frame(1, 0, 8'hB2, 2);
        push_frame(1, 1, 8'hC2, 2);
        frm_wr_v[2] = 1'b1;
        frm_wr_v[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frm_wr_v[2] = 1'b0;
        frm_wr_v[3] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            vpat[10-i] = vld[1];
            @(negedge clk);
        end
        chk("t2_valid_pattern", {21'd0, vpat}, 32'b110_1101_1011);
        wait_done(1, "t2");
        chk("t2_cnt_zero", {20'd0, u_dut_b.frm_cnt1, u_dut_b.frm_cnt0}, 0);

        // T3: stall with tx_ready 1,0,0,1
        push_frame(0, 0, 8'hD0, 4);
        frm_wr_v[0] = 1'b1;
        @(negedge clk);
        frm_wr_v[0] = 1'b0;
        wait_valid(0, "t3_start");
        tx_ready_v[0] = 1'b1;
        @(negedge clk);
        tx_ready_v[0] = 1'b0;
        @(negedge clk);
        chk("t3_stall_data", {24'd0, data_w[0]}, 32'hD1);
        @(negedge clk);
        tx_ready_v[0] = 1'b1;
        @(negedge clk);
        wait_done(0, "t3");

        // T4: underrun after 2 of 4 bytes
        push_byte(0, 0, 8'hE0, 1'b0, 1'b1);
        push_byte(0, 0, 8'hE1, 1'b0, 1'b1);
        frm_wr_v[0] = 1'b1;
        @(negedge clk);
        frm_wr_v[0] = 1'b0;
        wait_valid(0, "t4_start");
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("t4_underrun", {29'd0, vld[0], busy_w[0], grant_w[0]}, 32'b010);
            @(negedge clk);
        end
        push_byte(0, 0, 8'hE2, 1'b0, 1'b1);
        push_byte(0, 0, 8'hE3, 1'b1, 1'b1);
        wait_done(0, "t4");

        // T5: commit and last-byte pop in the same cycle
        push_frame(0, 0, 8'hF0, 2);
        frm_wr_v[0] = 1'b1;
        @(negedge clk);
        frm_wr_v[0] = 1'b0;
        wait_valid(0, "t5_start");
        @(negedge clk);
        chk("t5_last_on_head", {31'd0, vld[0] & last_w[0]}, 1);
        push_frame(0, 0, 8'h50, 2);
        frm_wr_v[0] = 1'b1;
        @(negedge clk);
        frm_wr_v[0] = 1'b0;
        chk("t5_cnt_held", {26'd0, u_dut_a.frm_cnt0}, 1);
        gap_n = 0;
        while (!vld[0] && gap_n < 40) begin
            gap_n++;
            @(negedge clk);
        end
        chk("t5_restart_delay", gap_n, 13);
        wait_done(0, "t5");

        // T6: reset asserted while byte 2 is presented
        push_byte(0, 0, 8'h60, 1'b0, 1'b1);
        push_byte(0, 0, 8'h61, 1'b0, 1'b0);
        push_byte(0, 0, 8'h62, 1'b0, 1'b0);
        push_byte(0, 0, 8'h63, 1'b1, 1'b0);
        frm_wr_v[0] = 1'b1;
        @(negedge clk);
        frm_wr_v[0] = 1'b0;
        wait_valid(0, "t6_start");
        @(negedge clk);
        chk("t6_byte2_shown", {24'd0, data_w[0]}, 32'h61);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_now", {28'd0, vld[0], rd0_w[0], rd1_w[0], busy_w[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_cnt_cleared", {26'd0, u_dut_a.frm_cnt0}, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_no_restart", {30'd0, vld[0], busy_w[0]}, 0);
        end
        chk("end_exp_a", exp_q[0].size(), 0);
        chk("end_exp_b", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/umio_tx_arb.md
Name: umio_tx_arb

Overview:
- Two-source round-robin frame arbiter that drains two show-ahead byte FIFOs (9-bit entries: bit 8 = last-of-frame, bits 7:0 = data) into one MAC TX byte stream.
- Keeps a complete-frame count per source, so a frame is only started once it is fully buffered and the MAC never underruns mid-frame.
- Inserts a programmable inter-frame gap between frames.
- Sits between the per-channel TX FIFOs and the 1G MAC transmit path.

Parameters:
- CNT_W, 6, width of each per-source complete-frame counter.
- IFG_LEN, 12, idle cycles inserted after each frame's last byte; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src0_data  in  9  head entry of FIFO 0; valid whenever src0_empty=0.
- src0_empty  in  1  FIFO 0 empty flag.
- src0_rd_en  out  1  pop FIFO 0 head this cycle.
- src0_frm_wr  in  1  one-cycle pulse: writer committed the last byte of a frame into FIFO 0.
- src1_data, src1_empty, src1_rd_en, src1_frm_wr: same as source 0.
- tx_data  out  8  byte to MAC.
- tx_last  out  1  tx_data is the last byte of the frame.
- tx_valid  out  1  tx_data/tx_last valid.
- tx_ready  in  1  MAC accepts the byte this cycle when tx_valid=1.
- grant  out  1  source currently owning the output; held after the frame completes.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, frm_cnt0/1=0, grant=0, rr_pri=0, gap counter=0.
  - All outputs 0; takes effect immediately even mid-frame; no partial-frame recovery.
- Frame counters (per source, CNT_W bits):
  - +1 on srcN_frm_wr.
  - -1 when the last byte (data bit 8=1) of source N is popped.
  - Both in the same cycle: unchanged.
  - Increment at all-ones saturates (increment lost).
  - Decrement at 0 is impossible by construction; the counter stays 0.
- State machine:
  - IDLE:
    - if frm_cnt_rr_pri>0, grant<=rr_pri;
    - else if the other source's frm_cnt>0, grant<=other source;
    - go to XFER on the next edge. No output in the IDLE cycle.
  - XFER:
    - tx_valid = !src_empty[grant].
    - tx_data/tx_last = src_data[grant] bits 7:0 / bit 8.
    - src_rd_en[grant] = tx_valid & tx_ready; the other rd_en is 0.
    - On a pop with bit 8=1: rr_pri<=~grant, gap counter<=IFG_LEN, then go to GAP if IFG_LEN>0, else IDLE.
  - GAP: decrement the gap counter each cycle; at 1, go to IDLE. tx_valid=0.
- Latency:
  - frm_wr pulse to first tx_valid: 2 cycles (counter register, then IDLE decision).
  - Back-to-back frames with IFG_LEN=0: 1 idle cycle (the IDLE cycle) between frames.
- Handshake:
  - tx_data/tx_last stay stable while tx_valid=1 and tx_ready=0 (FIFO head is not popped).
- Underrun: if src_empty[grant]=1 mid-frame, tx_valid=0 and the arbiter stays in XFER until data arrives. Frame is not aborted.
- Arbitration is fair: the priority source alternates after every completed frame. With both sources continuously loaded, the output alternates 0,1,0,1.
- tx_ready is ignored outside XFER.

Optional Feature:
- Macro UMIO_TX_ARB_STAT_EN.
- Defined:
  - Adds outputs stat_frm0, stat_frm1 (16 bits each): count frames transmitted per source, incremented on the last-byte pop, wrapping at 0xFFFF.
  - Adds stat_ovf (1 bit, sticky until reset): set when a frame counter increment is lost to saturation.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 3-byte frame 0xA1,0xA2,0xA3(last) into src0 with frm_wr, tx_ready=1 -> tx_valid high 2 cycles after frm_wr for 3 consecutive cycles, tx_last on 0xA3, then 12 cycles of tx_valid=0, busy=0 after.
- Two 2-byte frames queued in each source simultaneously, IFG_LEN=0 -> output order src0,src1,src0,src1; grant toggles after each last byte; frame counters return to 0.
- tx_ready toggling 1,0,0,1 during a frame -> tx_data held during stall cycles, no byte duplicated or dropped, srcN_rd_en=0 while tx_ready=0.
- src0 empties after 2 of 4 bytes (frame count forced) -> tx_valid=0 during the gap, resumes with byte 3 when refilled, grant unchanged.
- frm_wr and last-byte pop on the same source in the same cycle with frm_cnt=1 -> frm_cnt stays 1; next frame starts after the gap.
- rst_n asserted mid-frame at byte 2 -> tx_valid, rd_en and busy go 0 immediately; after release, counters are 0 and no transfer starts without a new frm_wr.
